// File: rtl/mario_motion_ctrl.sv
// Frame-synchronous motion controller for Mario: movement FSM plus sprite-centre
// position. All state moves on the frame_tick pulse only.
module mario_motion_ctrl #(
  parameter logic [9:0] INIT_X     = 10'd100,
  parameter logic [8:0] INIT_Y     = 9'd412,
  parameter int         WALK_STEP  = 2,
  parameter int         CLIMB_STEP = 1,
  parameter int         JUMP_V     = 6,
  parameter int         GRAVITY    = 1,
  parameter int         MAX_FALL   = 6,
  parameter int         FALL_LIMIT = 60,
  parameter int         DIE_FRAMES = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       on_floor,
  input  logic       on_ladder,
  input  logic       hit,
  output logic [9:0] posX,
  output logic [8:0] posY,
  output logic [2:0] state,
  output logic       respawn
);

  typedef enum logic [2:0] {
    S_INITIAL  = 3'b000,
    S_FLYING   = 3'b001,
    S_JUMPING  = 3'b010,
    S_WALKING  = 3'b011,
    S_STANDING = 3'b100,
    S_DYING    = 3'b101,
    S_CLAMPING = 3'b110
  } state_t;

  localparam logic signed [10:0] X_MIN = 11'sd67;
  localparam logic signed [10:0] X_MAX = 11'sd573;
  localparam logic signed [10:0] Y_MIN = 11'sd68;
  localparam logic signed [10:0] Y_MAX = 11'sd412;
  localparam logic signed [10:0] WS    = 11'(WALK_STEP);
  localparam logic signed [10:0] CS    = 11'(CLIMB_STEP);
  localparam logic [3:0]         JV    = 4'(JUMP_V);
  localparam logic [3:0]         GR    = 4'(GRAVITY);
  localparam logic [3:0]         MF    = 4'(MAX_FALL);
  localparam logic [7:0]         FL    = 8'(FALL_LIMIT);
  localparam logic [6:0]         DLAST = 7'(DIE_FRAMES - 1);

  function automatic logic [9:0] clamp_x(input logic signed [10:0] v);
    logic [9:0] r;
    if (v < X_MIN)      r = X_MIN[9:0];
    else if (v > X_MAX) r = X_MAX[9:0];
    else                r = v[9:0];
    return r;
  endfunction

  function automatic logic [8:0] clamp_y(input logic signed [10:0] v);
    logic [8:0] r;
    if (v < Y_MIN)      r = Y_MIN[8:0];
    else if (v > Y_MAX) r = Y_MAX[8:0];
    else                r = v[8:0];
    return r;
  endfunction

  state_t     state_q, st_n;
  logic [3:0] vy_q, vy_n;
  logic [7:0] fall_q, fall_n;
  logic [6:0] die_q, die_n;
  logic [9:0] x_n;
  logic [8:0] y_n;
  logic       resp_n;

  logic              floor, one_dir;
  logic signed [10:0] px, py, vys, dx, y_jmp;
  logic [9:0]        x_mv;
  logic [8:0]        y_up, y_dn, y_fall;
  logic [8:0]        fsum;
  logic [3:0]        vinc, vdec;

  // Bottom row of the board is always solid ground.
  assign floor   = on_floor | (posY == Y_MAX[8:0]);
  assign one_dir = btn_left ^ btn_right;
  assign px      = signed'({1'b0, posX});
  assign py      = signed'({2'b00, posY});
  assign vys     = signed'({7'd0, vy_q});
  assign dx      = !one_dir ? 11'sd0 : (btn_right ? WS : -WS);
  assign x_mv    = clamp_x(px + dx);
  assign y_up    = clamp_y(py - CS);
  assign y_dn    = clamp_y(py + CS);
  assign y_jmp   = py - vys;
  assign y_fall  = clamp_y(py + vys);
  assign fsum    = {1'b0, fall_q} + {5'd0, vy_q};
  assign vinc    = vy_q + GR;
  assign vdec    = (vy_q > GR) ? vy_q - GR : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INITIAL;
      posX    <= INIT_X;
      posY    <= INIT_Y;
      vy_q    <= '0;
      fall_q  <= '0;
      die_q   <= '0;
      respawn <= 1'b0;
    end else begin
      state_q <= st_n;
      posX    <= x_n;
      posY    <= y_n;
      vy_q    <= vy_n;
      fall_q  <= fall_n;
      die_q   <= die_n;
      respawn <= resp_n;
    end
  end

  always_comb begin
    st_n   = state_q;
    x_n    = posX;
    y_n    = posY;
    vy_n   = vy_q;
    fall_n = fall_q;
    die_n  = die_q;
    resp_n = 1'b0;
    if (frame_tick) begin
      if (hit && state_q != S_INITIAL && state_q != S_DYING) begin
        st_n   = S_DYING;
        vy_n   = '0;
        fall_n = '0;
        die_n  = '0;
      end else begin
        unique case (state_q)
          S_INITIAL: st_n = S_STANDING;
          S_STANDING, S_WALKING: begin
            if (state_q == S_WALKING) x_n = x_mv;
            if (!floor && !on_ladder) begin
              st_n   = S_FLYING;
              vy_n   = '0;
              fall_n = '0;
            end else if (btn_jump) begin
              st_n = S_JUMPING;
              vy_n = JV;
            end else if (btn_up && on_ladder) begin
              st_n = S_CLAMPING;
              y_n  = y_up;
            end else if (one_dir) begin
              st_n = S_WALKING;
              x_n  = x_mv;
            end else begin
              st_n = S_STANDING;
            end
          end
          S_JUMPING: begin
            x_n = x_mv;
            if (y_jmp <= Y_MIN) begin
              // Bumped the ceiling: kill the ascent and start falling.
              y_n    = Y_MIN[8:0];
              vy_n   = '0;
              fall_n = '0;
              st_n   = S_FLYING;
            end else begin
              y_n  = y_jmp[8:0];
              vy_n = vdec;
              if (vdec == 4'd0) begin
                st_n   = S_FLYING;
                fall_n = '0;
              end
            end
          end
          S_FLYING: begin
            x_n = x_mv;
            if (floor) begin
              st_n   = (fall_q >= FL) ? S_DYING : S_STANDING;
              vy_n   = '0;
              fall_n = '0;
              die_n  = '0;
            end else begin
              y_n    = y_fall;
              fall_n = fsum[8] ? 8'hFF : fsum[7:0];
              vy_n   = (vinc > MF) ? MF : vinc;
            end
          end
          S_CLAMPING: begin
            if (!on_ladder) begin
              if (floor) st_n = S_STANDING;
              else begin
                st_n   = S_FLYING;
                vy_n   = '0;
                fall_n = '0;
              end
            end else if (btn_up && !btn_down) begin
              y_n = y_up;
            end else if (btn_down && !btn_up) begin
              y_n = y_dn;
            end
          end
          S_DYING: begin
            if (die_q == DLAST) begin
              st_n   = S_INITIAL;
              x_n    = INIT_X;
              y_n    = INIT_Y;
              die_n  = '0;
              resp_n = 1'b1;
            end else begin
              die_n = die_q + 7'd1;
            end
          end
          default: st_n = S_INITIAL;
        endcase
      end
    end
  end

  assign state = state_q;

endmodule
